mem_port_arbiter: RTL and testbench

Shares one single-ported unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the pipelined RISC-V core. Both pipeline ports use a level req / pulsed ready handshake. The memory side uses a req/ack handshake with variable latency. Data accesses have priority, and a bounded starvation counter guarantees fetch progress. The pipeline control derives stalls from the absence of ready.

---
 rtl/riscv_arb_pkg.sv | 7 +
 rtl/arb_starve_cnt.sv | 18 +
 rtl/mem_port_arbiter.sv | 95 +++++++++
 tb/tb_mem_port_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_arb_pkg.sv
// riscv_arb_pkg: shared state/grant encodings for the instruction/data memory port arbiter.
package riscv_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} arb_state_e;
  typedef enum logic [1:0] {GR_NONE, GR_DATA, GR_FETCH} grant_e;
  localparam int ARB_DATA_W = 32;
  localparam logic [ARB_DATA_W/8-1:0] BE_ALL = '1;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of data grants taken while a fetch waits.
module arb_starve_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  input  logic [W-1:0] i_sat,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != i_sat) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, data first with fetch anti-starvation.
// Optional ARB_TIMEOUT_EN adds an mem_ack watchdog and the mem_err output.
module mem_port_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                mem_err
`endif
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  arb_state_e r_state, w_next;
  grant_e w_win;
  logic [CNT_W-1:0] w_starve_cnt;
  logic w_to, w_done;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tcnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_tcnt <= '0;
    else r_tcnt <= (r_state == IDLE) ? '0 : r_tcnt + 1'b1;
  assign w_to = !mem_ack && r_tcnt == TW'(TIMEOUT_CYC);
  assign mem_err = (r_state != IDLE) && w_to;
`else
  assign w_to = 1'b0;
`endif
  assign w_done = (r_state != IDLE) && (mem_ack || w_to);
  always_comb begin
    w_win = (r_state != IDLE) ? GR_NONE :
            (dm_req && !(if_req && w_starve_cnt == CNT_W'(STARVE_MAX))) ? GR_DATA :
            if_req ? GR_FETCH : GR_NONE;
    w_next = w_done ? IDLE :
             (w_win == GR_DATA) ? GNT_D :
             (w_win == GR_FETCH) ? GNT_I : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      r_state <= w_next;
      if (w_win == GR_DATA) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (w_win == GR_FETCH) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end
    end
  arb_starve_cnt #(.W(CNT_W)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_win == GR_DATA && if_req),
    .i_clr (w_win == GR_FETCH),
    .i_sat (CNT_W'(STARVE_MAX)),
    .o_cnt (w_starve_cnt)
  );
  assign mem_req  = r_state != IDLE;
  assign if_ready = w_done && r_state == GNT_I;
  assign dm_ready = w_done && r_state == GNT_D;
  assign if_rdata = (r_state == GNT_I && mem_ack) ? mem_rdata : '0;
  assign dm_rdata = (r_state == GNT_D && mem_ack) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latching, starvation, latency and reset.
module tb_mem_port_arbiter;
  import riscv_arb_pkg::*;
  logic clk = 0, rst = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [3:0] dm_be = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_ready, dm_ready, mem_req, mem_we;
  logic [3:0] mem_be;
`ifdef ARB_TIMEOUT_EN
  logic mem_err;
`endif
  int n_assert = 0, n_fail = 0, n_pulse;

  mem_port_arbiter #(
    .STARVE_MAX(4)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef ARB_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_outs", {mem_we, if_ready, dm_ready, mem_be}, 0);
    chk("rst_addr", mem_addr, 0);
    @(negedge clk);
    rst = 0;
    step();
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    // ack while idle must be ignored
    mem_ack = 1; mem_rdata = 32'h1111_1111; #1;
    chk("idle_ack_rdy", {30'd0, if_ready, dm_ready}, 0);
    chk("idle_ack_rdata", dm_rdata | if_rdata, 0);
    step();
    mem_ack = 0;
    chk("idle_ack_state", 32'(dut.r_state), 32'(IDLE));
    // fetch only
    if_req = 1; if_addr = 32'h10; #1;
    chk("f_no_early_rdy", {31'd0, if_ready}, 0);
    step();
    mem_ack = 1; mem_rdata = 32'h0050_0093; #1;
    chk("f_mem_req", {31'd0, mem_req}, 1);
    chk("f_be", {28'd0, mem_be}, 32'hF);
    chk("f_we", {31'd0, mem_we}, 0);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_ready", {31'd0, if_ready}, 1);
    chk("f_rdata", if_rdata, 32'h0050_0093);
    step();
    mem_ack = 0; if_req = 0; #1;
    chk("f_rdy_done", {31'd0, if_ready}, 0);
    chk("f_rdata_zero", if_rdata, 0);
    chk("f_idle", {31'd0, mem_req}, 0);
    // both at once: data first, then fetch
    if_req = 1; if_addr = 32'h14;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
    step();
    mem_ack = 1; mem_rdata = 32'h5555_AAAA; #1;
    chk("b_d_addr", mem_addr, 32'h200);
    chk("b_d_we", {31'd0, mem_we}, 1);
    chk("b_d_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("b_d_be", {28'd0, mem_be}, 32'h3);
    chk("b_d_rdy", {30'd0, dm_ready, if_ready}, 32'h2);
    chk("b_d_rdata", dm_rdata, 32'h5555_AAAA);
    step();
    mem_ack = 0; dm_req = 0; #1;
    chk("b_gap", {31'd0, mem_req}, 0);
    chk("b_cnt1", 32'(dut.w_starve_cnt), 1);
    step();
    mem_ack = 1; mem_rdata = 32'h0000_0013; #1;
    chk("b_i_addr", mem_addr, 32'h14);
    chk("b_i_be", {28'd0, mem_be}, 32'hF);
    chk("b_i_rdy", {30'd0, dm_ready, if_ready}, 32'h1);
    chk("b_i_rdata", if_rdata, 32'h13);
    step();
    mem_ack = 0; if_req = 0;
    chk("b_cnt0", 32'(dut.w_starve_cnt), 0);
    // starvation: four data grants then fetch forced
    if_req = 1; if_addr = 32'h40;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; dm_be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      mem_ack = 1; #1;
      chk($sformatf("s_grant%0d", k), mem_addr, (k < 4) ? 32'h300 : 32'h40);
      chk($sformatf("s_rdy%0d", k), {30'd0, dm_ready, if_ready}, (k < 4) ? 32'h2 : 32'h1);
      step();
      mem_ack = 0;
    end
    if_req = 0;
    chk("s_cnt_clr", 32'(dut.w_starve_cnt), 0);
    step();
    mem_ack = 1; #1;
    chk("s_data_again", mem_addr, 32'h300);
    step();
    mem_ack = 0; dm_req = 0;
    // variable latency: seven waiting cycles, ack on the eighth
    dm_req = 1; dm_we = 1; dm_addr = 32'h400; dm_wdata = 32'h1234_5678; dm_be = 4'hC;
    n_pulse = 0;
    step();
    for (int c = 0; c < 7; c++) begin
      #1;
      chk($sformatf("v_stable%0d", c),
          mem_addr ^ mem_wdata ^ {27'd0, mem_we, mem_be}, 32'h400 ^ 32'h1234_5678 ^ 32'h1C);
      n_pulse += int'(dm_ready);
      step();
    end
    mem_ack = 1; #1;
    chk("v_ack_addr", mem_addr, 32'h400);
    n_pulse += int'(dm_ready);
    step();
    mem_ack = 0; dm_req = 0; #1;
    n_pulse += int'(dm_ready);
    chk("v_one_pulse", 32'(n_pulse), 1);
    // reset in the third waiting cycle of a data grant
    dm_req = 1; dm_we = 0; dm_addr = 32'h500; dm_be = 4'hF;
    step();
    step();
    step();
    chk("r_waiting", {31'd0, mem_req}, 1);
    rst = 1; mem_ack = 1; #1;
    chk("r_mem_req", {31'd0, mem_req}, 0);
    chk("r_no_rdy", {31'd0, dm_ready}, 0);
    step();
    rst = 0; mem_ack = 0; dm_req = 0;
    step();
    chk("r_idle", 32'(dut.r_state), 32'(IDLE));
    dm_req = 1;
    step();
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D; #1;
    chk("r_fresh_rdy", {31'd0, dm_ready}, 1);
    chk("r_fresh_rdata", dm_rdata, 32'hCAFE_F00D);
    step();
    mem_ack = 0; dm_req = 0;
`ifdef ARB_TIMEOUT_EN
    dm_req = 1; dm_addr = 32'h600; mem_rdata = 32'hFFFF_FFFF;
    step();
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("t_wait%0d", c), {30'd0, dm_ready, mem_err}, 0);
      step();
    end
    #1;
    chk("t_rdy_err", {30'd0, dm_ready, mem_err}, 32'h3);
    chk("t_rdata", dm_rdata, 0);
    step();
    dm_req = 0; #1;
    chk("t_idle", {29'd0, mem_req, dm_ready, mem_err}, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
